sss_search_ctrl: RTL and testbench



---
 rtl/sss_ctrl_pkg.sv | 18 +
 rtl/sss_search_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sss_search_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sss_ctrl_pkg.sv
// Shared types and constants for the SSS search sequencing controller.
package sss_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SSS,
        ST_FEED,
        ST_SEARCH
    } sss_state_t;

    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_SHORT_SYM = 2'd2;
    localparam logic [1:0] ERR_NOT_INIT  = 2'd3;

    localparam int N_ID_1_W = 9;
    localparam int N_ID_W   = 10;

endpackage

// File: rtl/sss_search_ctrl.sv
// Sequences the SSS detector: waits for the SSS symbol, gates 127 bits in,
// supervises the hypothesis search with a timeout and publishes N_id.
module sss_search_ctrl
    import sss_ctrl_pkg::*;
#(
    parameter int SSS_LEN        = 127,
    parameter int SSS_SYM_OFFSET = 1,
    parameter int INIT_CYCLES    = 160,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [1:0]          N_id_2_i,
    input  logic                N_id_2_valid_i,
    input  logic                symbol_start_i,
    input  logic                s_axis_in_tdata,
    input  logic                s_axis_in_tvalid,
    output logic                det_reset_no,
    output logic                det_tdata_o,
    output logic                det_tvalid_o,
    output logic [1:0]          det_N_id_2_o,
    output logic                det_N_id_2_valid_o,
    input  logic [N_ID_1_W-1:0] det_N_id_1_i,
    input  logic [N_ID_W-1:0]   det_N_id_i,
    input  logic                det_valid_i,
    output logic [N_ID_W-1:0]   N_id_o,
    output logic [N_ID_1_W-1:0] N_id_1_o,
    output logic [1:0]          N_id_2_o,
    output logic                N_id_valid_o,
    output logic                busy_o,
    output logic                error_o,
    output logic [1:0]          error_code_o,
    output logic                overrun_o
);

    localparam int SYM_W  = $clog2(SSS_SYM_OFFSET + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SSS_SYM_OFFSET);
    localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(INIT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]        BIT_LAST  = 7'(SSS_LEN - 1);

    sss_state_t state_q, state_d;

    logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d, sym_inc;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [6:0]          bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                det_reset_d, det_tdata_d, det_tvalid_d;
    logic [1:0]          n_id_2_lat_d;
    logic                det_n2_valid_d;
    logic [N_ID_W-1:0]   n_id_d;
    logic [N_ID_1_W-1:0] n_id_1_d;
    logic [1:0]          n_id_2_res_d;
    logic                n_id_valid_d, error_d, overrun_d;
    logic [1:0]          error_code_d;

    assign sym_inc = sym_cnt_q + SYM_W'(1);
    assign busy_o  = (state_q != ST_IDLE);

    always_comb begin
        state_d        = state_q;
        sym_cnt_d      = sym_cnt_q;
        init_cnt_d     = init_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        det_reset_d    = det_reset_no;
        det_tdata_d    = det_tdata_o;
        det_tvalid_d   = 1'b0;
        n_id_2_lat_d   = det_N_id_2_o;
        det_n2_valid_d = 1'b0;
        n_id_d         = N_id_o;
        n_id_1_d       = N_id_1_o;
        n_id_2_res_d   = N_id_2_o;
        n_id_valid_d   = 1'b0;
        error_d        = 1'b0;
        error_code_d   = error_code_o;
        overrun_d      = 1'b0;

        if (state_q != ST_IDLE) begin
            if (init_cnt_q < INIT_DONE) init_cnt_d = init_cnt_q + INIT_W'(1);
            if (N_id_2_valid_i) overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                det_reset_d = 1'b0;
                if (N_id_2_valid_i) begin
                    n_id_2_lat_d   = N_id_2_i;
                    det_reset_d    = 1'b1;
                    det_n2_valid_d = 1'b1;
                    sym_cnt_d      = '0;
                    init_cnt_d     = '0;
                    state_d        = ST_WAIT_SSS;
                end
            end
            ST_WAIT_SSS: begin
                if (symbol_start_i) begin
                    sym_cnt_d = sym_inc;
                    if (sym_inc == SYM_LAST) begin
                        if (init_cnt_q < INIT_DONE) begin
                            error_d      = 1'b1;
                            error_code_d = ERR_NOT_INIT;
                            det_reset_d  = 1'b0;
                            state_d      = ST_IDLE;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = ST_FEED;
                        end
                    end
                end
            end
            ST_FEED: begin
                // The final bit takes priority over a coincident symbol start.
                if (s_axis_in_tvalid) begin
                    det_tdata_d  = s_axis_in_tdata;
                    det_tvalid_d = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 7'd1;
                end
                if (s_axis_in_tvalid && bit_cnt_q == BIT_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_SEARCH;
                end else if (symbol_start_i) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_SHORT_SYM;
                    det_reset_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (det_valid_i) begin
                    n_id_d       = det_N_id_i;
                    n_id_1_d     = det_N_id_1_i;
                    n_id_2_res_d = det_N_id_2_o;
                    n_id_valid_d = 1'b1;
                    det_reset_d  = 1'b0;
                    state_d      = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_TIMEOUT;
                    det_reset_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                det_reset_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q            <= ST_IDLE;
            sym_cnt_q          <= '0;
            init_cnt_q         <= '0;
            bit_cnt_q          <= '0;
            tmo_cnt_q          <= '0;
            det_reset_no       <= 1'b0;
            det_tdata_o        <= 1'b0;
            det_tvalid_o       <= 1'b0;
            det_N_id_2_o       <= '0;
            det_N_id_2_valid_o <= 1'b0;
            N_id_o             <= '0;
            N_id_1_o           <= '0;
            N_id_2_o           <= '0;
            N_id_valid_o       <= 1'b0;
            error_o            <= 1'b0;
            error_code_o       <= '0;
            overrun_o          <= 1'b0;
        end else begin
            state_q            <= state_d;
            sym_cnt_q          <= sym_cnt_d;
            init_cnt_q         <= init_cnt_d;
            bit_cnt_q          <= bit_cnt_d;
            tmo_cnt_q          <= tmo_cnt_d;
            det_reset_no       <= det_reset_d;
            det_tdata_o        <= det_tdata_d;
            det_tvalid_o       <= det_tvalid_d;
            det_N_id_2_o       <= n_id_2_lat_d;
            det_N_id_2_valid_o <= det_n2_valid_d;
            N_id_o             <= n_id_d;
            N_id_1_o           <= n_id_1_d;
            N_id_2_o           <= n_id_2_res_d;
            N_id_valid_o       <= n_id_valid_d;
            error_o            <= error_d;
            error_code_o       <= error_code_d;
            overrun_o          <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sss_search_ctrl.sv
// Self-checking bench for sss_search_ctrl; the bench plays PSS source, demapper and detector.
module tb_sss_search_ctrl;
    import sss_ctrl_pkg::*;

    logic                clk_i = 1'b0;
    logic                reset_ni = 1'b0;
    logic [1:0]          N_id_2_i = '0;
    logic                N_id_2_valid_i = 1'b0;
    logic                symbol_start_i = 1'b0;
    logic                s_axis_in_tdata = 1'b0;
    logic                s_axis_in_tvalid = 1'b0;
    logic                det_reset_no, det_tdata_o, det_tvalid_o;
    logic [1:0]          det_N_id_2_o;
    logic                det_N_id_2_valid_o;
    logic [N_ID_1_W-1:0] det_N_id_1_i = '0;
    logic [N_ID_W-1:0]   det_N_id_i = '0;
    logic                det_valid_i = 1'b0;
    logic [N_ID_W-1:0]   N_id_o;
    logic [N_ID_1_W-1:0] N_id_1_o;
    logic [1:0]          N_id_2_o;
    logic                N_id_valid_o, busy_o, error_o, overrun_o;
    logic [1:0]          error_code_o;

    sss_search_ctrl #(
        .SSS_LEN(127), .SSS_SYM_OFFSET(1), .INIT_CYCLES(160), .TIMEOUT_CYCLES(48000)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .N_id_2_i(N_id_2_i), .N_id_2_valid_i(N_id_2_valid_i),
        .symbol_start_i(symbol_start_i),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
        .det_reset_no(det_reset_no), .det_tdata_o(det_tdata_o), .det_tvalid_o(det_tvalid_o),
        .det_N_id_2_o(det_N_id_2_o), .det_N_id_2_valid_o(det_N_id_2_valid_o),
        .det_N_id_1_i(det_N_id_1_i), .det_N_id_i(det_N_id_i), .det_valid_i(det_valid_i),
        .N_id_o(N_id_o), .N_id_1_o(N_id_1_o), .N_id_2_o(N_id_2_o), .N_id_valid_o(N_id_valid_o),
        .busy_o(busy_o), .error_o(error_o), .error_code_o(error_code_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor samples just after each rising edge; the main thread checks on falling edges.
    int unsigned n_fwd = 0, n_res = 0, n_err = 0, n_ovr = 0;
    logic        fwd_q[$];
    logic        sent_q[$];

    always @(posedge clk_i) begin
        #1;
        if (det_tvalid_o) begin
            n_fwd++;
            fwd_q.push_back(det_tdata_o);
        end
        if (N_id_valid_o) n_res++;
        if (error_o)      n_err++;
        if (overrun_o)    n_ovr++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] n2;
        int         n1;
        int         nbits;
        int         gap;
        int         lat;
        bit         sym_acc;
        bit         sym_last;
        bit         ovr;
    } vec_t;

    task automatic accept(input logic [1:0] n2, input bit with_sym);
        @(negedge clk_i);
        N_id_2_valid_i = 1'b1;
        N_id_2_i       = n2;
        symbol_start_i = with_sym;
        @(negedge clk_i);
        N_id_2_valid_i = 1'b0;
        symbol_start_i = 1'b0;
        chk("acc_det_reset", det_reset_no, 1);
        chk("acc_n2_valid", det_N_id_2_valid_o, 1);
        chk("acc_n2", det_N_id_2_o, n2);
        chk("acc_busy", busy_o, 1);
    endtask

    // Leaves the last bit driven; the caller clears tvalid on the next falling edge.
    task automatic feed(input int nbits, input bit sym_last);
        int i = 0;
        logic b;
        while (i < nbits) begin
            @(negedge clk_i);
            symbol_start_i = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                s_axis_in_tvalid = 1'b0;
            end else begin
                b = 1'($urandom);
                s_axis_in_tvalid = 1'b1;
                s_axis_in_tdata  = b;
                sent_q.push_back(b);
                if (sym_last && i == 126) symbol_start_i = 1'b1;
                i++;
            end
        end
    endtask

    task automatic check_fwd(input string nm, input int base, input int exp_n);
        int got_n = fwd_q.size() - base;
        int bad = 0;
        chk({nm, "_fwd_count"}, got_n, exp_n);
        for (int i = 0; i < got_n && i < exp_n; i++)
            if (fwd_q[base + i] !== sent_q[i]) bad++;
        chk({nm, "_fwd_bits_bad"}, bad, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base = fwd_q.size();
        int unsigned r0 = n_res, e0 = n_err, o0 = n_ovr;
        int exp_fwd = (v.nbits < 127) ? v.nbits : 127;
        int exp_nid = 3 * v.n1 + int'(v.n2);
        bit seen = 0;
        string nm = $sformatf("v%0d", idx);
        sent_q.delete();
        accept(v.n2, v.sym_acc);
        repeat (v.gap) @(negedge clk_i);
        symbol_start_i = 1'b1;
        feed(v.nbits, v.sym_last);
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b0;
        symbol_start_i   = 1'b0;
        if (v.nbits < 127) begin
            symbol_start_i = 1'b1;
            @(negedge clk_i);
            symbol_start_i = 1'b0;
            chk({nm, "_short_err"}, error_o, 1);
            chk({nm, "_short_code"}, error_code_o, ERR_SHORT_SYM);
            chk({nm, "_short_det_reset"}, det_reset_no, 0);
            chk({nm, "_short_busy"}, busy_o, 0);
            chk({nm, "_short_no_result"}, n_res - r0, 0);
        end else begin
            if (v.ovr) begin
                N_id_2_valid_i = 1'b1;
                N_id_2_i       = ~v.n2;
                @(negedge clk_i);
                N_id_2_valid_i = 1'b0;
                chk({nm, "_overrun"}, overrun_o, 1);
                chk({nm, "_overrun_busy"}, busy_o, 1);
            end
            repeat (v.lat) @(negedge clk_i);
            det_valid_i  = 1'b1;
            det_N_id_i   = N_ID_W'(exp_nid);
            det_N_id_1_i = N_ID_1_W'(v.n1);
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk_i);
                seen = N_id_valid_o;
            end
            chk({nm, "_result_pulse"}, seen, 1);
            chk({nm, "_N_id"}, N_id_o, exp_nid);
            chk({nm, "_N_id_1"}, N_id_1_o, v.n1);
            chk({nm, "_N_id_2"}, N_id_2_o, v.n2);
            chk({nm, "_res_det_reset"}, det_reset_no, 0);
            chk({nm, "_res_no_err"}, n_err - e0, 0);
            det_valid_i = 1'b0;
            @(negedge clk_i);
            chk({nm, "_pulse_one_cycle"}, N_id_valid_o, 0);
            chk({nm, "_N_id_held"}, N_id_o, exp_nid);
            chk({nm, "_idle"}, busy_o, 0);
        end
        chk({nm, "_overrun_count"}, n_ovr - o0, v.ovr ? 1 : 0);
        check_fwd(nm, base, exp_fwd);
        repeat (3) @(negedge clk_i);
    endtask

    vec_t vecs[$];

    initial begin : main
        vec_t v;
        int base, cnt;
        int unsigned r0;

        vecs.push_back('{n2: 2'd1, n1: 57,  nbits: 127, gap: 300, lat: 20, sym_acc: 1, sym_last: 0, ovr: 0});
        vecs.push_back('{n2: 2'd0, n1: 0,   nbits: 127, gap: 170, lat: 0,  sym_acc: 0, sym_last: 0, ovr: 0});
        vecs.push_back('{n2: 2'd2, n1: 335, nbits: 130, gap: 250, lat: 5,  sym_acc: 0, sym_last: 0, ovr: 1});
        vecs.push_back('{n2: 2'd1, n1: 100, nbits: 100, gap: 300, lat: 0,  sym_acc: 1, sym_last: 0, ovr: 0});
        vecs.push_back('{n2: 2'd2, n1: 200, nbits: 127, gap: 200, lat: 3,  sym_acc: 0, sym_last: 1, ovr: 0});
        vecs.push_back('{n2: 2'd0, n1: 1,   nbits: 1,   gap: 180, lat: 0,  sym_acc: 0, sym_last: 0, ovr: 0});
        vecs.push_back('{n2: 2'd1, n1: 2,   nbits: 126, gap: 180, lat: 0,  sym_acc: 0, sym_last: 0, ovr: 0});
        for (int i = 0; i < 6; i++) begin
            v.n2       = 2'($urandom_range(0, 2));
            v.n1       = int'($urandom_range(0, 335));
            v.nbits    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 126))
                                                     : int'($urandom_range(127, 130));
            v.gap      = int'($urandom_range(170, 400));
            v.lat      = int'($urandom_range(0, 50));
            v.sym_acc  = 1'($urandom);
            v.sym_last = (v.nbits == 127) ? 1'($urandom) : 1'b0;
            v.ovr      = 1'($urandom);
            vecs.push_back(v);
        end

        #23;
        chk("rst_det_reset", det_reset_no, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_outputs", {det_tvalid_o, det_N_id_2_valid_o, N_id_valid_o, error_o,
                            overrun_o, error_code_o, N_id_o, N_id_1_o, N_id_2_o}, 0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Init guard: SSS symbol start arrives before the detector has initialised.
        base = fwd_q.size();
        accept(2'd0, 1'b0);
        repeat (50) @(negedge clk_i);
        symbol_start_i = 1'b1;
        @(negedge clk_i);
        symbol_start_i = 1'b0;
        chk("init_err", error_o, 1);
        chk("init_code", error_code_o, ERR_NOT_INIT);
        chk("init_busy", busy_o, 0);
        chk("init_det_reset", det_reset_no, 0);
        sent_q.delete();
        feed(10, 1'b0);
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("init_fwd_none", fwd_q.size() - base, 0);

        // Timeout: the detector never reports.
        r0 = n_res;
        sent_q.delete();
        accept(2'd2, 1'b0);
        repeat (200) @(negedge clk_i);
        symbol_start_i = 1'b1;
        feed(127, 1'b0);
        cnt = 0;
        for (int c = 1; c <= 50000 && cnt == 0; c++) begin
            @(negedge clk_i);
            if (c == 1) s_axis_in_tvalid = 1'b0;
            if (error_o) cnt = c;
        end
        chk("tmo_cycles", cnt, 48001);
        chk("tmo_code", error_code_o, ERR_TIMEOUT);
        chk("tmo_det_reset", det_reset_no, 0);
        chk("tmo_no_result", n_res - r0, 0);
        repeat (3) @(negedge clk_i);

        // Asynchronous reset part-way through FEED, followed by a fresh search.
        sent_q.delete();
        accept(2'd1, 1'b0);
        repeat (200) @(negedge clk_i);
        symbol_start_i = 1'b1;
        feed(60, 1'b0);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_det_reset", det_reset_no, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_outputs", {det_tvalid_o, det_tdata_o, det_N_id_2_o, N_id_valid_o, error_o,
                             overrun_o, error_code_o, N_id_o, N_id_1_o, N_id_2_o}, 0);
        s_axis_in_tvalid = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        v = '{n2: 2'd2, n1: 99, nbits: 127, gap: 220, lat: 7, sym_acc: 0, sym_last: 0, ovr: 0};
        run_vec(v, 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

endmodule
